timer_multi: RTL and testbench
==============================

Name: timer_multi

Overview:
Parametrised multi-channel timer. It replaces the single-channel enable/clear/period timer on the Wishbone-attached peripheral port.
- Each channel has its own CTRL, PERIOD, VALUE and COMPARE registers, and supports periodic or one-shot mode.
- A shared prescaler generates the count tick.
- Wrap and compare events are latched into a W1C interrupt status register, masked by an enable register, and ORed into one irq line for the CPU.

Parameters:
NCH, 4, number of timer channels (1..16).
WIDTH, 32, counter/period/compare width (1..32); register reads are zero-extended to 32 bits.
PSC_W, 16, prescaler register width.
ADDR_W, 5, word-address width; must satisfy 2^ADDR_W >= 4*NCH+3.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
we  in  1  register write strobe from the bus wrapper, single cycle
addr  in  ADDR_W  word address
din  in  32  write data
dout  out  32  read data, combinational from addr
irq  out  1  |(STATUS & IRQ_EN), registered state, combinational OR
ch_val  out  NCH*WIDTH  debug: VALUE of channel c on bits [c*WIDTH +: WIDTH]

Behaviour:
- Register map, with c = channel:
  - 4c+0 CTRL
  - 4c+1 PERIOD
  - 4c+2 VALUE (read/write)
  - 4c+3 COMPARE
  - 4*NCH+0 STATUS
  - 4*NCH+1 IRQ_EN
  - 4*NCH+2 PSC
  - Every other address reads 0; writes to it are ignored.
- CTRL bits:
  - [0] EN.
  - [1] CLR: write-only pulse that clears VALUE in the write cycle; always reads 0.
  - [2] ONESHOT.
  - Other bits read 0.
- STATUS bits:
  - [c] WRAP_c.
  - [NCH+c] MATCH_c.
  - Width 2*NCH; writing 1 clears a bit (W1C), writing 0 has no effect.
- IRQ_EN has the same bit layout as STATUS; it is plain read/write.
- Reset values: CTRL=0, PERIOD=all-ones, VALUE=0, COMPARE=all-ones, STATUS=0, IRQ_EN=0, PSC=0, prescaler counter=0. Therefore irq=0 and ch_val=0.
- Writes take effect on the clk edge where we=1. Register writes use din[WIDTH-1:0] (PSC uses din[PSC_W-1:0]).
- Prescaler:
  - psc_cnt counts from 0 to PSC.
  - tick=1 in the cycle where psc_cnt==PSC; psc_cnt then returns to 0.
  - PSC=0 gives a tick every cycle.
  - A write to PSC also zeroes psc_cnt.
- Channel update each cycle, first matching rule wins:
  1. CTRL write with din[1]=1: VALUE<=0.
  2. VALUE write: VALUE<=din.
  3. tick and EN:
     - If VALUE>=PERIOD: VALUE<=0 and set WRAP_c. If ONESHOT=1, also EN<=0, unless CTRL is written in the same cycle (the bus write wins).
     - Otherwise VALUE<=VALUE+1, modulo 2^WIDTH.
  4. Otherwise hold.
- MATCH_c is set when tick and EN and VALUE==COMPARE, evaluated on the pre-update VALUE. It is set even if rule 1 or 2 overrides the count in that cycle.
- Both WRAP_c and MATCH_c can set in the same cycle.
- Set beats clear: a W1C write and an event on the same bit in the same cycle leave the bit at 1.
- The PERIOD or COMPARE value used in a cycle is the pre-write register value; a new value applies from the next cycle.
- Lowering PERIOD below VALUE causes a wrap on the next tick (>= comparison).
- Channels are independent; they all share the tick.
- Latency:
  - Event to STATUS bit: 1 cycle.
  - STATUS to irq: 0 cycles.
  - Register write to readback: 1 cycle.
- Reset asserted mid-count returns all state to reset values at the next edge; no event is latched in that cycle.

Test Plan:
1. Reset, then read every mapped address -> CTRL=0, PERIOD=0xFFFFFFFF, VALUE=0, COMPARE=0xFFFFFFFF, STATUS/IRQ_EN/PSC=0; irq=0; unmapped address reads 0.
2. ch0: PERIOD=3, CTRL=1, PSC=0 -> VALUE sequence 1,2,3,0,1; STATUS[0] set on the cycle after VALUE=3; IRQ_EN=1 raises irq; writing STATUS=1 drops irq.
3. ch1: PERIOD=5, COMPARE=2, CTRL=5 (EN+ONESHOT), PSC=2 -> VALUE increments every 3 cycles; MATCH_1 (bit NCH+1) sets when VALUE leaves 2; after reaching 5, VALUE=0, CTRL reads 4, and VALUE stays 0.
4. ch2 running at VALUE=7: write CTRL=3 -> VALUE=0 next cycle, CTRL reads 1. Write VALUE=100 with PERIOD=50 -> wrap on the next tick.
5. W1C on STATUS bit c in the same cycle as a WRAP_c event -> bit remains 1. All channels running with different periods -> only the matching bits set; ch_val slices track each VALUE.
6. WIDTH=8, NCH=2 instance: PERIOD=0xFF, VALUE=0xFE, EN -> VALUE goes to 0xFF then 0, WRAP set; reads show bits [31:8]=0.

Source files
------------

// File: rtl/timer_multi.sv
// Multi-channel timer: shared prescaler tick, per-channel periodic/one-shot
// counters, W1C wrap/match status with enable mask folded into one irq.
module timer_multi #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned PSC_W  = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  output logic                 irq,
  output logic [NCH*WIDTH-1:0] ch_val
);
  localparam int unsigned SW = 2 * NCH;
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4 * NCH);
  localparam logic [ADDR_W-1:0] A_IRQ_EN = ADDR_W'(4 * NCH + 1);
  localparam logic [ADDR_W-1:0] A_PSC    = ADDR_W'(4 * NCH + 2);

  logic [NCH-1:0][2:0]       w_ctrl;
  logic [NCH-1:0][WIDTH-1:0] w_period;
  logic [NCH-1:0][WIDTH-1:0] w_value;
  logic [NCH-1:0][WIDTH-1:0] w_compare;
  logic [NCH-1:0]            w_wrap;
  logic [NCH-1:0]            w_match;
  logic [SW-1:0]             r_status;
  logic [SW-1:0]             r_irq_en;
  logic [PSC_W-1:0]          r_psc;
  logic [PSC_W-1:0]          r_psc_cnt;
  logic                      w_tick;
  logic                      w_unused;

  // din bits above the implemented register widths are don't-care
  assign w_unused = ^din;

  assign w_tick = (r_psc_cnt == r_psc);

  // Shared prescaler; reprogramming restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc     <= '0;
      r_psc_cnt <= '0;
    end else if (we && (addr == A_PSC)) begin
      r_psc     <= din[PSC_W-1:0];
      r_psc_cnt <= '0;
    end else if (w_tick) begin
      r_psc_cnt <= '0;
    end else begin
      r_psc_cnt <= r_psc_cnt + PSC_W'(1);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(4 * c);
    localparam logic [ADDR_W-1:0] A_PERIOD  = ADDR_W'(4 * c + 1);
    localparam logic [ADDR_W-1:0] A_VALUE   = ADDR_W'(4 * c + 2);
    localparam logic [ADDR_W-1:0] A_COMPARE = ADDR_W'(4 * c + 3);

    logic             r_en;
    logic             r_oneshot;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_compare;
    logic             w_ctrl_wr;
    logic             w_value_wr;
    logic             w_clr;
    logic             w_run;

    assign w_ctrl_wr  = we && (addr == A_CTRL);
    assign w_value_wr = we && (addr == A_VALUE);
    assign w_clr      = w_ctrl_wr && din[1];
    assign w_run      = w_tick && r_en;

    // A bus clear or load pre-empts the wrap, but not the match
    assign w_wrap[c]  = w_run && !w_clr && !w_value_wr && (r_value >= r_period);
    assign w_match[c] = w_run && (r_value == r_compare);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_en      <= 1'b0;
        r_oneshot <= 1'b0;
        r_period  <= '1;
        r_value   <= '0;
        r_compare <= '1;
      end else begin
        if (w_ctrl_wr) begin
          r_en      <= din[0];
          r_oneshot <= din[2];
        end else if (w_wrap[c] && r_oneshot) begin
          r_en <= 1'b0;
        end
        if (we && (addr == A_PERIOD)) r_period <= din[WIDTH-1:0];
        if (we && (addr == A_COMPARE)) r_compare <= din[WIDTH-1:0];
        if (w_clr) begin
          r_value <= '0;
        end else if (w_value_wr) begin
          r_value <= din[WIDTH-1:0];
        end else if (w_run) begin
          r_value <= w_wrap[c] ? '0 : r_value + WIDTH'(1);
        end
      end
    end

    assign w_ctrl[c]    = {r_oneshot, 1'b0, r_en};
    assign w_period[c]  = r_period;
    assign w_value[c]   = r_value;
    assign w_compare[c] = r_compare;
  end

  // Event set wins over a simultaneous W1C of the same bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= '0;
      r_irq_en <= '0;
    end else begin
      if (we && (addr == A_STATUS)) begin
        r_status <= (r_status & ~din[SW-1:0]) | {w_match, w_wrap};
      end else begin
        r_status <= r_status | {w_match, w_wrap};
      end
      if (we && (addr == A_IRQ_EN)) r_irq_en <= din[SW-1:0];
    end
  end

  assign irq    = |(r_status & r_irq_en);
  assign ch_val = w_value;

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (addr == ADDR_W'(4 * i))     dout = 32'(w_ctrl[i]);
      if (addr == ADDR_W'(4 * i + 1)) dout = 32'(w_period[i]);
      if (addr == ADDR_W'(4 * i + 2)) dout = 32'(w_value[i]);
      if (addr == ADDR_W'(4 * i + 3)) dout = 32'(w_compare[i]);
    end
    if (addr == A_STATUS) dout = 32'(r_status);
    if (addr == A_IRQ_EN) dout = 32'(r_irq_en);
    if (addr == A_PSC)    dout = 32'(r_psc);
  end

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the register map.
module tb_timer_multi;
  localparam int unsigned NCH = 4;
  localparam int unsigned SW  = 2 * NCH;
  localparam int unsigned A_ST = 16, A_IE = 17, A_PSC = 18;

  logic         clk = 1'b0;
  logic         rst, we;
  logic [4:0]   addr;
  logic [31:0]  din;
  logic [31:0]  dout;
  logic         irq;
  logic [127:0] ch_val;

  logic         n_we;
  logic [3:0]   n_addr;
  logic [31:0]  n_din;
  logic [31:0]  n_dout;
  logic         n_irq_o;
  logic [15:0]  n_chv_o;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0]  g_rd, g_erd, n_rd;
  logic         g_irq, g_eirq, n_irq;
  logic [127:0] g_chv, g_echv;
  logic [15:0]  n_chv;

  timer_multi u_dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .din(din),
    .dout(dout), .irq(irq), .ch_val(ch_val)
  );

  timer_multi #(.NCH(2), .WIDTH(8), .PSC_W(8), .ADDR_W(4)) u_narrow (
    .clk(clk), .rst(rst), .we(n_we), .addr(n_addr), .din(n_din),
    .dout(n_dout), .irq(n_irq_o), .ch_val(n_chv_o)
  );

  always #5 clk = ~clk;

  // Behavioural model of the default-parameter instance
  int unsigned m_period[NCH], m_value[NCH], m_cmp[NCH];
  bit          m_en[NCH], m_os[NCH];
  int unsigned m_st, m_ie, m_psc, m_pcnt;

  function automatic void model_reset();
    for (int unsigned c = 0; c < NCH; c++) begin
      m_period[c] = 32'hFFFF_FFFF; m_cmp[c] = 32'hFFFF_FFFF;
      m_value[c] = 0; m_en[c] = 0; m_os[c] = 0;
    end
    m_st = 0; m_ie = 0; m_psc = 0; m_pcnt = 0;
  endfunction

  function automatic void model_step(input bit w, input int unsigned a, input logic [31:0] d);
    bit tick;
    int unsigned ev;
    tick = (m_pcnt == m_psc);
    ev = 0;
    for (int unsigned c = 0; c < NCH; c++) begin
      bit ctrl_w, run;
      int unsigned nv;
      ctrl_w = w && (a == 4*c);
      run = tick && m_en[c];
      nv = m_value[c];
      if (run && m_value[c] == m_cmp[c]) ev |= 32'd1 << (NCH + c);
      if (ctrl_w && d[1]) nv = 0;
      else if (w && a == 4*c + 2) nv = d;
      else if (run) begin
        if (m_value[c] >= m_period[c]) begin
          nv = 0;
          ev |= 32'd1 << c;
          if (m_os[c] && !ctrl_w) m_en[c] = 0;
        end else nv = m_value[c] + 1;
      end
      if (ctrl_w) begin m_en[c] = d[0]; m_os[c] = d[2]; end
      if (w && a == 4*c + 1) m_period[c] = d;
      if (w && a == 4*c + 3) m_cmp[c] = d;
      m_value[c] = nv;
    end
    if (w && a == A_ST) m_st = m_st & ~d;
    m_st |= ev;
    if (w && a == A_IE) m_ie = d & ((32'd1 << SW) - 1);
    if (w && a == A_PSC) begin m_psc = d & 32'hFFFF; m_pcnt = 0; end
    else if (tick) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
  endfunction

  function automatic logic [31:0] m_read(input int unsigned a);
    if (a < 4*NCH) begin
      case (a % 4)
        0: return 32'((m_os[a/4] ? 4 : 0) + (m_en[a/4] ? 1 : 0));
        1: return m_period[a/4];
        2: return m_value[a/4];
        default: return m_cmp[a/4];
      endcase
    end
    if (a == A_ST) return m_st;
    if (a == A_IE) return m_ie;
    if (a == A_PSC) return m_psc;
    return 32'd0;
  endfunction

  function automatic logic [127:0] m_chv();
    logic [127:0] v;
    for (int unsigned c = 0; c < NCH; c++) v[c*32 +: 32] = m_value[c];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step(we, 32'(addr), din);
  end

  // One bus cycle: drive at negedge, sample pre-edge state, release after edge
  task automatic drive(input bit w, input int unsigned a, input logic [31:0] d);
    @(negedge clk);
    we = w; addr = 5'(a); din = d;
    #2;
    g_rd = dout; g_irq = irq; g_chv = ch_val;
    g_erd = m_read(a); g_eirq = |(m_st & m_ie); g_echv = m_chv();
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic ndrive(input bit w, input int unsigned a, input logic [31:0] d);
    @(negedge clk);
    n_we = w; n_addr = 4'(a); n_din = d;
    #2;
    n_rd = n_dout; n_irq = n_irq_o; n_chv = n_chv_o;
    @(posedge clk);
    #1 n_we = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1; we = 1'b0; n_we = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    apply_reset(2);
    for (int unsigned a = 0; a < 32; a++) begin
      drive(0, a, 0);
      exp = (a < 16 && (a % 4 == 1 || a % 4 == 3)) ? 32'hFFFF_FFFF : 32'h0;
      n_cmp++;
      if (g_rd !== exp) begin
        n_fail++; $display("FAIL reset_read addr=%0d got=%h exp=%h", a, g_rd, exp);
      end
      n_cmp++;
      if (g_irq !== 1'b0 || g_chv !== 128'h0) begin
        n_fail++; $display("FAIL reset_outputs irq=%b ch_val=%h exp 0/0", g_irq, g_chv);
      end
    end
  endtask

  task automatic test_periodic();
    int unsigned seq[6] = '{0, 1, 2, 3, 0, 1};
    apply_reset(2);
    drive(1, 1, 3);
    drive(1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(0, A_ST, 0);
      n_cmp++;
      if (g_chv[31:0] !== seq[i] || g_rd !== ((i >= 4) ? 32'h1 : 32'h0)) begin
        n_fail++;
        $display("FAIL periodic_seq i=%0d value=%0d status=%h exp value=%0d status=%0d",
                 i, g_chv[31:0], g_rd, seq[i], (i >= 4));
      end
    end
    drive(1, 0, 0);
    drive(1, A_IE, 1);
    n_cmp++;
    if (g_irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b exp=0", g_irq); end
    drive(0, A_ST, 0);
    n_cmp++;
    if (g_irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise got=%b exp=1", g_irq); end
    drive(1, A_ST, 1);
    drive(0, A_ST, 0);
    n_cmp++;
    if (g_irq !== 1'b0 || g_rd !== 32'h0) begin
      n_fail++; $display("FAIL irq_w1c irq=%b status=%h exp 0/0", g_irq, g_rd);
    end
  endtask

  task automatic test_oneshot();
    int unsigned ra[5] = '{4, 5, 6, 7, A_ST};
    int n3;
    apply_reset(2);
    drive(1, 5, 5);
    drive(1, 7, 2);
    drive(1, A_PSC, 2);
    drive(1, 4, 5);
    n3 = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, ra[i % 5], 0);
      if (g_chv[63:32] == 32'd3) n3++;
      n_cmp++;
      if (g_rd !== g_erd || g_chv !== g_echv) begin
        n_fail++;
        $display("FAIL oneshot_model i=%0d rd=%h exp=%h ch_val=%h exp=%h", i, g_rd, g_erd, g_chv, g_echv);
      end
    end
    n_cmp++;
    if (n3 != 3) begin n_fail++; $display("FAIL oneshot_rate cycles_at_3=%0d exp=3", n3); end
    drive(0, 4, 0);
    n_cmp++;
    if (g_rd !== 32'h4) begin n_fail++; $display("FAIL oneshot_ctrl got=%h exp=4", g_rd); end
    drive(0, 6, 0);
    n_cmp++;
    if (g_rd !== 32'h0) begin n_fail++; $display("FAIL oneshot_value got=%h exp=0", g_rd); end
    drive(0, A_ST, 0);
    n_cmp++;
    if (g_rd !== 32'h22) begin n_fail++; $display("FAIL oneshot_status got=%h exp=22", g_rd); end
  endtask

  task automatic test_clr_value();
    bit found;
    apply_reset(2);
    drive(1, 8, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(0, 10, 0);
      if (g_rd == 32'd6) found = 1;
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL clr_reach6 got=%h exp=6", g_rd); end
    drive(1, 8, 3);
    n_cmp++;
    if (g_chv[95:64] !== 32'd7) begin n_fail++; $display("FAIL clr_pre got=%0d exp=7", g_chv[95:64]); end
    drive(0, 8, 0);
    n_cmp++;
    if (g_rd !== 32'h1 || g_chv[95:64] !== 32'd0) begin
      n_fail++; $display("FAIL clr_after ctrl=%h value=%0d exp 1/0", g_rd, g_chv[95:64]);
    end
    drive(1, 9, 50);
    drive(1, 10, 100);
    drive(0, 10, 0);
    n_cmp++;
    if (g_rd !== 32'd100) begin n_fail++; $display("FAIL load_value got=%0d exp=100", g_rd); end
    drive(0, A_ST, 0);
    n_cmp++;
    if (g_rd[2] !== 1'b1 || g_chv[95:64] !== 32'd0) begin
      n_fail++; $display("FAIL load_wrap status=%h value=%0d exp bit2=1 value=0", g_rd, g_chv[95:64]);
    end
  endtask

  task automatic test_w1c_race();
    apply_reset(2);
    drive(1, 1, 3);
    drive(1, 0, 1);
    repeat (3) drive(0, A_ST, 0);
    drive(1, A_ST, 1);
    drive(1, A_ST, 1);
    n_cmp++;
    if (g_rd !== 32'h1) begin n_fail++; $display("FAIL w1c_set_wins1 got=%h exp=1", g_rd); end
    drive(0, A_ST, 0);
    n_cmp++;
    if (g_rd !== 32'h0) begin n_fail++; $display("FAIL w1c_clear got=%h exp=0", g_rd); end
    drive(0, A_ST, 0);
    drive(1, A_ST, 1);
    drive(0, A_ST, 0);
    n_cmp++;
    if (g_rd !== 32'h1) begin n_fail++; $display("FAIL w1c_set_wins2 got=%h exp=1", g_rd); end
  endtask

  task automatic test_reset_midcount();
    apply_reset(2);
    drive(1, 3, 0);
    drive(1, 1, 0);
    drive(1, A_IE, 32'hFF);
    drive(1, 0, 1);
    drive(0, A_ST, 0);
    drive(0, A_ST, 0);
    n_cmp++;
    if (g_rd !== 32'h11 || g_irq !== 1'b1) begin
      n_fail++; $display("FAIL mid_events status=%h irq=%b exp 11/1", g_rd, g_irq);
    end
    apply_reset(1);
    drive(0, A_ST, 0);
    n_cmp++;
    if (g_rd !== 32'h0 || g_irq !== 1'b0 || g_chv !== 128'h0) begin
      n_fail++; $display("FAIL mid_reset status=%h irq=%b ch_val=%h exp 0", g_rd, g_irq, g_chv);
    end
    drive(0, 0, 0);
    n_cmp++;
    if (g_rd !== 32'h0) begin n_fail++; $display("FAIL mid_reset_ctrl got=%h exp=0", g_rd); end
  endtask

  task automatic test_random();
    int unsigned init_a[12] = '{1, 5, 9, 13, 3, 7, 11, 15, 0, 4, 8, 12};
    int unsigned init_d[12] = '{3, 5, 7, 10, 1, 4, 2, 9, 1, 1, 5, 1};
    apply_reset(2);
    drive(1, A_IE, 32'hFF);
    for (int i = 0; i < 12; i++) drive(1, init_a[i], init_d[i]);
    for (int i = 0; i < 500; i++) begin
      int unsigned r, a;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      if (r < 45) begin
        a = $urandom_range(0, 31);
        d = 0;
      end else begin
        a = $urandom_range(0, 19);
        if (a < 16) begin
          case (a % 4)
            0: d = $urandom_range(0, 7);
            2: d = (r > 95) ? $urandom : $urandom_range(0, 14);
            default: d = (r > 97) ? $urandom : $urandom_range(0, 12);
          endcase
        end else if (a == A_PSC) d = $urandom_range(0, 2);
        else d = $urandom;
      end
      drive(r >= 45, a, d);
      n_cmp++;
      if (g_rd !== g_erd || g_irq !== g_eirq || g_chv !== g_echv) begin
        n_fail++;
        $display("FAIL random i=%0d addr=%0d rd=%h exp=%h irq=%b exp=%b ch_val=%h exp=%h",
                 i, a, g_rd, g_erd, g_irq, g_eirq, g_chv, g_echv);
      end
    end
  endtask

  task automatic test_narrow();
    apply_reset(2);
    ndrive(0, 1, 0);
    n_cmp++;
    if (n_rd !== 32'hFF) begin n_fail++; $display("FAIL narrow_period got=%h exp=000000ff", n_rd); end
    ndrive(1, 3, 32'hFFFF_FFFF);
    ndrive(0, 3, 0);
    n_cmp++;
    if (n_rd !== 32'hFF) begin n_fail++; $display("FAIL narrow_cmp got=%h exp=000000ff", n_rd); end
    ndrive(1, 2, 32'hFFFF_FFFE);
    ndrive(1, 0, 1);
    ndrive(0, 2, 0);
    n_cmp++;
    if (n_rd !== 32'hFE) begin n_fail++; $display("FAIL narrow_fe got=%h exp=fe", n_rd); end
    ndrive(0, 2, 0);
    n_cmp++;
    if (n_rd !== 32'hFF || n_chv[7:0] !== 8'hFF) begin
      n_fail++; $display("FAIL narrow_ff rd=%h ch_val=%h exp ff", n_rd, n_chv);
    end
    ndrive(0, 2, 0);
    n_cmp++;
    if (n_rd !== 32'h0) begin n_fail++; $display("FAIL narrow_wrap_value got=%h exp=0", n_rd); end
    ndrive(0, 8, 0);
    n_cmp++;
    if (n_rd !== 32'h5 || n_irq !== 1'b0) begin
      n_fail++; $display("FAIL narrow_status got=%h irq=%b exp 5/0", n_rd, n_irq);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; din = '0;
    n_we = 1'b0; n_addr = '0; n_din = '0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_clr_value();
    test_w1c_race();
    test_reset_midcount();
    test_random();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
